// File: rtl/slc3_panel_pkg.sv
// Shared types and defaults for the SLC-3 front-panel input conditioner.
package slc3_panel_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } panel_state_t;

  localparam int unsigned DB_CYCLES_DEF     = 50000;
  localparam int unsigned REPEAT_CYCLES_DEF = 0;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/panel_debounce.sv
// One pushbutton channel: 2-FF synchroniser, debounce FSM, press/release/repeat pulses.
module panel_debounce
  import slc3_panel_pkg::*;
#(
  parameter int unsigned DB_CYCLES     = DB_CYCLES_DEF,
  parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_repeat
);

  localparam int unsigned CNT_MAX  = max_u(DB_CYCLES, REPEAT_CYCLES);
  localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);
  localparam int unsigned DB_LAST  = DB_CYCLES - 1;
  localparam int unsigned RPT_LAST = (REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0;

  logic [1:0]       sync_q;
  panel_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] rpt_q, rpt_d;
  logic             level_d, press_d, release_d, repeat_d;
  logic             s;

  assign s = sync_q[1];

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_W'(CNT_MAX)) ? v : v + CNT_W'(1);
  endfunction

  // Sync FFs reset to released so reset release never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= 2'b11;
      state_q     <= IDLE;
      cnt_q       <= '0;
      rpt_q       <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      btn_repeat  <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], key_n};
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rpt_q       <= rpt_d;
      btn_level   <= level_d;
      btn_press   <= press_d;
      btn_release <= release_d;
      btn_repeat  <= repeat_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rpt_d     = rpt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    repeat_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!s) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      PRESS_WAIT: begin
        if (s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(DB_LAST)) begin
          state_d = HELD;
          cnt_d   = '0;
          rpt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      HELD: begin
        if (s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CNT_W'(1);
        end else if (REPEAT_CYCLES > 0) begin
          if (rpt_q == CNT_W'(RPT_LAST)) begin
            rpt_d    = '0;
            repeat_d = 1'b1;
          end else begin
            rpt_d = sat_inc(rpt_q);
          end
        end
      end
      RELEASE_WAIT: begin
        // A bounce back to HELD resumes the repeat period where it left off.
        if (!s) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(DB_LAST)) begin
          state_d   = IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    level_d = (state_d == HELD) || (state_d == RELEASE_WAIT);
  end

endmodule

// File: rtl/slc3_panel_ctrl.sv
// Front-panel conditioner: N debounced buttons plus synchronised and latched switch bank.
module slc3_panel_ctrl
  import slc3_panel_pkg::*;
#(
  parameter int unsigned N_BTN         = 2,
  parameter int unsigned SW_W          = 10,
  parameter int unsigned DB_CYCLES     = DB_CYCLES_DEF,
  parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_DEF,
  parameter int unsigned LATCH_BTN     = 1
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [N_BTN-1:0] KEY_n,
  input  logic [SW_W-1:0]  SW,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat,
  output logic [SW_W-1:0]  sw_sync,
  output logic [SW_W-1:0]  sw_latched
);

  logic [SW_W-1:0] sw_meta_q;
  logic [SW_W-1:0] sw_sync_q;
  logic [SW_W-1:0] sw_latched_q, sw_latched_d;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    panel_debounce #(
      .DB_CYCLES    (DB_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_debounce (
      .clk        (Clk),
      .rst_n      (Reset_n),
      .key_n      (KEY_n[i]),
      .btn_level  (btn_level[i]),
      .btn_press  (btn_press[i]),
      .btn_release(btn_release[i]),
      .btn_repeat (btn_repeat[i])
    );
  end

  // Only a real press reloads the snapshot; repeats leave it alone.
  always_comb begin
    sw_latched_d = sw_latched_q;
    if (btn_press[LATCH_BTN]) sw_latched_d = sw_sync_q;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sw_meta_q    <= '0;
      sw_sync_q    <= '0;
      sw_latched_q <= '0;
    end else begin
      sw_meta_q    <= SW;
      sw_sync_q    <= sw_meta_q;
      sw_latched_q <= sw_latched_d;
    end
  end

  assign sw_sync    = sw_sync_q;
  assign sw_latched = sw_latched_q;

endmodule

// File: tb/tb_slc3_panel_ctrl.sv
// Bench for slc3_panel_ctrl: directed scenarios plus random key/switch activity vs a run-length model.
module tb_slc3_panel_ctrl;

  localparam int unsigned N_BTN = 2;
  localparam int unsigned SW_W  = 10;
  localparam int unsigned DB    = 4;
  localparam int unsigned REP   = 6;
  localparam int unsigned LATCH = 1;
  localparam int          LAT   = 2 + DB;

  logic             Clk = 1'b0;
  logic             Reset_n;
  logic [N_BTN-1:0] KEY_n;
  logic [SW_W-1:0]  SW;
  logic [N_BTN-1:0] btn_level, btn_press, btn_release, btn_repeat;
  logic [SW_W-1:0]  sw_sync, sw_latched;

  always #5 Clk = ~Clk;

  slc3_panel_ctrl #(
    .N_BTN(N_BTN), .SW_W(SW_W), .DB_CYCLES(DB), .REPEAT_CYCLES(REP), .LATCH_BTN(LATCH)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .KEY_n(KEY_n), .SW(SW),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
    .btn_repeat(btn_repeat), .sw_sync(sw_sync), .sw_latched(sw_latched)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: a button toggles once its synchronised sample has disagreed with the
  // debounced level for DB consecutive clocks; repeat counts clocks spent agreeing.
  bit               m_s1 [N_BTN];
  bit               m_s2 [N_BTN];
  int               m_run[N_BTN];
  int               m_rpt[N_BTN];
  logic [N_BTN-1:0] m_lvl, m_prs, m_rel, m_rp;
  logic [SW_W-1:0]  m_sw1, m_sw2, m_swl;
  int               n_press[N_BTN];
  int               n_rel  [N_BTN];
  int               n_rpt  [N_BTN];

  task automatic model_reset();
    for (int b = 0; b < N_BTN; b++) begin
      m_s1[b] = 1'b1; m_s2[b] = 1'b1; m_run[b] = 0; m_rpt[b] = 0;
    end
    m_lvl = '0; m_prs = '0; m_rel = '0; m_rp = '0;
    m_sw1 = '0; m_sw2 = '0; m_swl = '0;
  endtask

  task automatic model_step();
    bit act;
    if (!Reset_n) begin
      model_reset();
    end else begin
      if (m_prs[LATCH]) m_swl = m_sw2;
      m_sw2 = m_sw1;
      m_sw1 = SW;
      m_prs = '0; m_rel = '0; m_rp = '0;
      for (int b = 0; b < N_BTN; b++) begin
        act = !m_s2[b];
        if (act != m_lvl[b]) begin
          m_run[b]++;
          if (m_run[b] == DB) begin
            m_lvl[b] = act;
            m_run[b] = 0;
            m_rpt[b] = 0;
            if (act) m_prs[b] = 1'b1;
            else     m_rel[b] = 1'b1;
          end
        end else begin
          if (m_run[b] == 0 && m_lvl[b]) begin
            m_rpt[b]++;
            if (m_rpt[b] == REP) begin
              m_rp[b]  = 1'b1;
              m_rpt[b] = 0;
            end
          end
          m_run[b] = 0;
        end
        m_s2[b] = m_s1[b];
        m_s1[b] = KEY_n[b];
      end
    end
  endtask

  task automatic compare_all();
    check_eq("btn_level",   32'(btn_level),   32'(m_lvl));
    check_eq("btn_press",   32'(btn_press),   32'(m_prs));
    check_eq("btn_release", 32'(btn_release), 32'(m_rel));
    check_eq("btn_repeat",  32'(btn_repeat),  32'(m_rp));
    check_eq("sw_sync",     32'(sw_sync),     32'(m_sw2));
    check_eq("sw_latched",  32'(sw_latched),  32'(m_swl));
  endtask

  // One clock: model follows the edge, DUT is sampled on the falling edge.
  task automatic step();
    @(posedge Clk);
    model_step();
    @(negedge Clk);
    compare_all();
    for (int b = 0; b < N_BTN; b++) begin
      if (btn_press[b])   n_press[b]++;
      if (btn_release[b]) n_rel[b]++;
      if (btn_repeat[b])  n_rpt[b]++;
    end
  endtask

  task automatic wait_pulse(input int b, input bit rel, input string tag);
    int lat = 0;
    for (int i = 1; i <= 20; i++) begin
      if (lat == 0) begin
        step();
        if (rel ? btn_release[b] : btn_press[b]) lat = i;
      end
    end
    check_eq(tag, 32'(lat), 32'(LAT));
  endtask

  task automatic check_all_zero(input string tag);
    check_eq(tag, 32'({btn_level, btn_press, btn_release, btn_repeat}), 32'd0);
    check_eq({tag, "_sw"}, 32'({sw_sync, sw_latched}), 32'd0);
  endtask

  initial begin
    int p, r;
    for (int b = 0; b < N_BTN; b++) begin
      n_press[b] = 0; n_rel[b] = 0; n_rpt[b] = 0;
    end
    model_reset();
    Reset_n = 1'b0;
    KEY_n   = 2'b11;
    SW      = 10'h00B;

    // Reset state and quiet release
    repeat (3) step();
    check_all_zero("reset_outputs");
    Reset_n = 1'b1;
    p = n_press[0] + n_press[1];
    repeat (2) step();
    check_eq("t1_sw_sync", 32'(sw_sync), 32'h00B);
    repeat (18) step();
    check_eq("t1_no_press", 32'(n_press[0] + n_press[1] - p), 32'd0);

    // Clean press and release of button 0
    KEY_n[0] = 1'b0;
    wait_pulse(0, 1'b0, "t2_press_lat");
    check_eq("t2_level", 32'(btn_level[0]), 32'd1);
    p = n_press[0];
    repeat (5) step();
    check_eq("t2_single_press", 32'(n_press[0] - p), 32'd0);
    KEY_n[0] = 1'b1;
    wait_pulse(0, 1'b1, "t2_release_lat");
    check_eq("t2_level_low", 32'(btn_level[0]), 32'd0);
    repeat (4) step();

    // Bounce on button 1
    p = n_press[1];
    for (int i = 0; i < 4; i++) begin
      KEY_n[1] = (i % 2 == 0) ? 1'b0 : 1'b1;
      step();
    end
    check_eq("t3_bounce_quiet", 32'(n_press[1] - p), 32'd0);
    KEY_n[1] = 1'b0;
    wait_pulse(1, 1'b0, "t3_press_lat");
    check_eq("t3_one_press", 32'(n_press[1] - p), 32'd1);
    KEY_n[1] = 1'b1;
    wait_pulse(1, 1'b1, "t3_release_lat");
    repeat (3) step();

    // Switch latch on button 1
    SW = 10'h05B;
    repeat (3) step();
    KEY_n[1] = 1'b0;
    wait_pulse(1, 1'b0, "t4_press_lat");
    repeat (2) step();
    check_eq("t4_latched", 32'(sw_latched), 32'h05B);
    SW = 10'h077;
    repeat (8) step();
    check_eq("t4_sync_follows", 32'(sw_sync), 32'h077);
    check_eq("t4_latched_holds", 32'(sw_latched), 32'h05B);
    KEY_n[1] = 1'b1;
    wait_pulse(1, 1'b1, "t4_release_lat");
    repeat (3) step();

    // Auto-repeat on button 0
    KEY_n[0] = 1'b0;
    wait_pulse(0, 1'b0, "t5_press_lat");
    r = n_rpt[0];
    repeat (30) step();
    check_eq("t5_repeats", 32'(n_rpt[0] - r), 32'd5);
    KEY_n[0] = 1'b1;
    r = n_rpt[0];
    repeat (12) step();
    check_eq("t5_no_repeat_release", 32'(n_rpt[0] - r), 32'd0);
    check_eq("t5_released", 32'(btn_level[0]), 32'd0);

    // Reset mid-PRESS_WAIT, then mid-HELD, with the key kept down
    KEY_n[0] = 1'b0;
    repeat (4) step();
    Reset_n = 1'b0;
    model_reset();
    #1;
    check_all_zero("t6_async_pw");
    repeat (2) step();
    Reset_n = 1'b1;
    wait_pulse(0, 1'b0, "t6_press_after_pw");
    repeat (3) step();
    Reset_n = 1'b0;
    model_reset();
    #1;
    check_all_zero("t6_async_held");
    repeat (2) step();
    Reset_n = 1'b1;
    p = n_press[0];
    wait_pulse(0, 1'b0, "t6_press_after_held");
    repeat (10) step();
    check_eq("t6_single_press", 32'(n_press[0] - p), 32'd1);
    KEY_n[0] = 1'b1;
    repeat (10) step();

    // Random key and switch activity
    for (int c = 0; c < 800; c++) begin
      for (int b = 0; b < N_BTN; b++)
        if ($urandom_range(7, 0) == 0) KEY_n[b] = ~KEY_n[b];
      if ($urandom_range(15, 0) == 0) SW = SW_W'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
